// File: rtl/sdram_pattern_check.sv
// SDRAM write/read-back pattern checker driving the sdram_top FIFO ports.
// Writes seed+1..seed+BURST_LEN, waits for the read FIFO to fill, then compares each word.
module sdram_pattern_check #(
  parameter int BURST_LEN = 10,
  parameter int WR_GAP    = 7,
  parameter int TIMEOUT   = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] seed,
  output logic        wr_fifo_wr_req,
  output logic [15:0] wr_fifo_wr_data,
  input  logic [9:0]  rd_fifo_num,
  output logic        rd_fifo_rd_req,
  input  logic [15:0] rd_fifo_rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [7:0]  err_cnt
);

  localparam int KW = (BURST_LEN < 2) ? 1 : $clog2(BURST_LEN);
  localparam int GW = (WR_GAP < 1) ? 1 : $clog2(WR_GAP + 1);
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [KW-1:0] K_LAST  = KW'(BURST_LEN - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(WR_GAP);
  localparam logic [TW-1:0] T_MAX   = TW'(TIMEOUT);
  localparam logic [9:0]    LVL_MIN = 10'(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WAIT,
    S_READ,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [15:0]   seed_q;
  logic [KW-1:0] k;
  logic [GW-1:0] gap;
  logic [TW-1:0] wcnt;
  logic [KW-1:0] j;
  logic          cmp_vld;
  logic [KW-1:0] cmp_idx;

  logic        push;
  logic        last_push;
  logic        last_pop;
  logic        lvl_ok;
  logic        expired;
  logic [15:0] exp_word;
  logic        miss;

  assign push      = (state == S_WRITE) && (gap == GAP_MAX);
  assign last_push = push && (k == K_LAST);
  assign last_pop  = (state == S_READ) && (j == K_LAST);
  assign lvl_ok    = rd_fifo_num >= LVL_MIN;
  assign expired   = (state == S_WAIT) && !lvl_ok && (wcnt == T_MAX);
  assign exp_word  = seed_q + 16'(cmp_idx) + 16'd1;
  assign miss      = cmp_vld && (rd_fifo_rd_data != exp_word);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start) state_n = S_WRITE;
      S_WRITE: if (last_push) state_n = S_WAIT;
      S_WAIT: begin
        if (lvl_ok) begin
          state_n = S_READ;
        end else if (expired) begin
          state_n = S_DONE;
        end
      end
      S_READ:  if (last_pop) state_n = S_CHECK;
      S_CHECK: state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    wr_fifo_wr_req  = 1'b0;
    wr_fifo_wr_data = '0;
    rd_fifo_rd_req  = 1'b0;
    rd_valid        = 1'b0;
    busy            = 1'b1;
    done            = 1'b0;
    unique case (state)
      S_IDLE: busy = 1'b0;
      S_WRITE: begin
        rd_valid        = 1'b1;
        wr_fifo_wr_req  = push;
        wr_fifo_wr_data = push ? (seed_q + 16'(k) + 16'd1) : '0;
      end
      S_WAIT:  rd_valid = 1'b1;
      S_READ:  rd_fifo_rd_req = 1'b1;
      S_CHECK: ;
      S_DONE:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Pop data lands one cycle late, so the compare trails the pop index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_q  <= '0;
      k       <= '0;
      gap     <= '0;
      wcnt    <= '0;
      j       <= '0;
      cmp_vld <= 1'b0;
      cmp_idx <= '0;
      err_cnt <= '0;
      pass    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      cmp_vld <= (state == S_READ);
      cmp_idx <= j;
      if (miss && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
      unique case (state)
        S_IDLE: begin
          if (start) begin
            seed_q  <= seed;
            pass    <= 1'b0;
            timeout <= 1'b0;
            err_cnt <= '0;
            k       <= '0;
            gap     <= '0;
          end
        end
        S_WRITE: begin
          if (push) begin
            gap <= '0;
            k   <= k + 1'b1;
          end else begin
            gap <= gap + 1'b1;
          end
          if (last_push) begin
            wcnt <= '0;
            j    <= '0;
          end
        end
        S_WAIT: begin
          j <= '0;
          if (expired) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
          end else if (!lvl_ok) begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_READ: j <= j + 1'b1;
        S_CHECK: ;
        S_DONE: pass <= (err_cnt == 8'd0) && !timeout;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sdram_pattern_check.md
SDRAM_PATTERN_CHECK -- requirements
Module: sdram_pattern_check

Interface
REQ-001 SHALL have parameter BURST_LEN, default 10: words written, then read back, per run (1..1023).
REQ-002 SHALL have parameter WR_GAP, default 7: idle cycles between consecutive write requests.
REQ-003 SHALL have parameter TIMEOUT, default 4095: maximum WAIT_RD cycles before the run aborts.
REQ-004 SHALL have port clk  in  1: single clock, same as wr_fifo_wr_clk / rd_fifo_rd_clk of sdram_top.
REQ-005 SHALL have port rst  in  1: asynchronous, active-high reset.
REQ-006 SHALL have port start  in  1: one-cycle run request; ignored while busy.
REQ-007 SHALL have port seed  in  16: pattern base, sampled on the accepted start.
REQ-008 SHALL have port wr_fifo_wr_req  out  1: write-FIFO push strobe.
REQ-009 SHALL have port wr_fifo_wr_data  out  16: write-FIFO data.
REQ-010 SHALL have port rd_fifo_num  in  10: read-FIFO fill level.
REQ-011 SHALL have port rd_fifo_rd_req  out  1: read-FIFO pop strobe (non-showahead FIFO).
REQ-012 SHALL have port rd_fifo_rd_data  in  16: read-FIFO data, valid one cycle after rd_fifo_rd_req.
REQ-013 SHALL have port rd_valid  out  1: permits the SDRAM controller to fill the read FIFO.
REQ-014 SHALL have port busy  out  1: a run is in progress.
REQ-015 SHALL have port done  out  1: one-cycle end-of-run pulse.
REQ-016 SHALL have port pass  out  1: last run matched all words with no timeout; held until the next accepted start.
REQ-017 SHALL have port timeout  out  1: last run aborted in WAIT_RD; held until the next accepted start.
REQ-018 SHALL have port err_cnt  out  8: mismatch count of the last run, saturating at 255.

Function
REQ-019 SHALL implement the FSM IDLE -> WRITE -> WAIT_RD -> READ -> CHECK -> DONE -> IDLE.
REQ-020 IDLE: start=1 -> WRITE; latch seed; clear pass, timeout and err_cnt; word index k=0.
REQ-021 WRITE: gap counter runs 0..WR_GAP; wr_fifo_wr_req=1 for exactly one cycle when counter==WR_GAP, with wr_fifo_wr_data=seed+k+1 (mod 2^16), then k increments and the counter returns to 0.
REQ-022 WRITE -> WAIT_RD in the cycle after push k=BURST_LEN-1; exactly BURST_LEN pushes per run.
REQ-023 rd_valid SHALL be 1 in WRITE and WAIT_RD, and 0 in all other states.
REQ-024 WAIT_RD: rd_fifo_num>=BURST_LEN -> READ; a wait counter is cleared on entry; counter==TIMEOUT with level still short -> DONE with timeout=1, pass=0.
REQ-025 READ: rd_fifo_rd_req=1 for exactly BURST_LEN consecutive cycles, then READ -> CHECK.
REQ-026 Each pop's data SHALL be compared in the following cycle against expected seed+j+1, where j = pop index; a mismatch increments err_cnt, saturating at 255 with no wrap.
REQ-027 CHECK: one cycle for the final compare, then -> DONE.
REQ-028 DONE: done=1 for one cycle; pass=1 iff err_cnt==0 and timeout==0; -> IDLE.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 A start asserted while busy=1 SHALL be ignored and have no side effects.
REQ-031 Comparison arithmetic SHALL be 16-bit modulo, so seed=16'hFFFF gives an expected first word of 16'h0000.
REQ-032 Counters SHALL be sized to the parameters, with no overflow at BURST_LEN=1023 or TIMEOUT=4095.

Reset
REQ-033 rst=1 SHALL force state IDLE asynchronously, regardless of state, including mid-run.
REQ-034 Under rst=1 the following outputs SHALL be 0: wr_fifo_wr_req, wr_fifo_wr_data, rd_fifo_rd_req, busy, done, pass, timeout, err_cnt.
REQ-035 Under rst=1, rd_valid SHALL be 0.
REQ-036 Under rst=1, all internal counters and the latched seed SHALL be 0.
REQ-037 Release of rst SHALL cause no push or pop until a new start is accepted.

Verification
REQ-038 Loopback with sdram_top and the SDRAM model, seed=0, defaults -> pushes 1..10 spaced 8 cycles apart; 10 pops; done pulse; pass=1; err_cnt=0.
REQ-039 Read FIFO model returning word 4 corrupted (XOR 16'h0001) -> err_cnt=1, pass=0, done pulse once.
REQ-040 rd_fifo_num held at 9 -> done exactly TIMEOUT+1 cycles after entering WAIT_RD; timeout=1; pass=0; rd_fifo_rd_req never asserted.
REQ-041 seed=16'hFFFE -> written words 16'hFFFF, 16'h0000, 16'h0001, ... ; pass=1.
REQ-042 rst pulsed during READ -> all outputs at reset values immediately; a new start completes a clean run with pass=1.
REQ-043 start re-asserted during WRITE, and BURST_LEN=300 with all words wrong -> no restart; exactly 10 pushes in the first case; err_cnt=255 saturated in the second.
